// File: rtl/io_port_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : io_port_ctrl                                                 |
// | Desc   : Keyboard input FIFO, printer output register and interrupt   |
// |          enable/request logic for a simple accumulator CPU.           |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
module io_port_ctrl #(
    parameter int IN_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] kbd_data,
    input  logic       kbd_valid,
    output logic       kbd_ready,
    output logic [7:0] inpr,
    output logic       fgi,
    input  logic       inp_ack,
    input  logic [7:0] outr_data,
    input  logic       out_ld,
    output logic       fgo,
    output logic [7:0] prn_data,
    output logic       prn_valid,
    input  logic       prn_ready,
    input  logic       ien_set,
    input  logic       ien_clr,
    output logic       ien,
    output logic       irq,
    output logic       out_ovr
);

    localparam int              c_ptr_w = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [c_ptr_w:0] c_full  = (c_ptr_w + 1)'(IN_DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [7:0]         r_mem [IN_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [7:0]         r_outr;
    logic               r_ien;
    logic               r_out_ovr;
    logic               w_push;
    logic               w_pop;
    logic               w_load;

    assign kbd_ready = (r_count != c_full);
    assign fgi       = (r_count != '0);
    assign inpr      = fgi ? r_mem[r_rd_ptr] : 8'h00;
    assign w_push    = kbd_valid && kbd_ready;
    // A pop needs a character already present; a same-cycle push does not count.
    assign w_pop     = inp_ack && fgi;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= kbd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        fgo         = 1'b1;
        prn_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (out_ld) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                fgo       = 1'b0;
                prn_valid = 1'b1;
                if (prn_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // OUTR keeps its value after the handshake so the printer side sees the last character.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outr    <= 8'h00;
            r_out_ovr <= 1'b0;
            r_ien     <= 1'b0;
        end else begin
            if (w_load) begin
                r_outr <= outr_data;
            end
            r_out_ovr <= out_ld && (r_state == S_SEND);
            if (ien_clr) begin
                r_ien <= 1'b0;
            end else if (ien_set) begin
                r_ien <= 1'b1;
            end
        end
    end

    assign prn_data = r_outr;
    assign out_ovr  = r_out_ovr;
    assign ien      = r_ien;
    assign irq      = r_ien && (fgi || fgo);

endmodule
`default_nettype wire

// File: tb/tb_io_port_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : tb_io_port_ctrl                                              |
// | Desc   : Directed scoreboard bench for io_port_ctrl (IN_DEPTH = 4).   |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_io_port_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] kbd_data;
    logic       kbd_valid;
    logic       kbd_ready;
    logic [7:0] inpr;
    logic       fgi;
    logic       inp_ack;
    logic [7:0] outr_data;
    logic       out_ld;
    logic       fgo;
    logic [7:0] prn_data;
    logic       prn_valid;
    logic       prn_ready;
    logic       ien_set;
    logic       ien_clr;
    logic       ien;
    logic       irq;
    logic       out_ovr;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] kbd_q[$];
    logic [7:0] prn_q[$];
    logic [7:0] exp8;
    int         model_cnt;

    io_port_ctrl #(.IN_DEPTH(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .kbd_data  (kbd_data),
        .kbd_valid (kbd_valid),
        .kbd_ready (kbd_ready),
        .inpr      (inpr),
        .fgi       (fgi),
        .inp_ack   (inp_ack),
        .outr_data (outr_data),
        .out_ld    (out_ld),
        .fgo       (fgo),
        .prn_data  (prn_data),
        .prn_valid (prn_valid),
        .prn_ready (prn_ready),
        .ien_set   (ien_set),
        .ien_clr   (ien_clr),
        .ien       (ien),
        .irq       (irq),
        .out_ovr   (out_ovr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; kbd_data = 8'h00; kbd_valid = 1'b0; inp_ack = 1'b0;
        outr_data = 8'h00; out_ld = 1'b0; prn_ready = 1'b0;
        ien_set = 1'b0; ien_clr = 1'b0;
        #3;
        chk8("rst_inpr", inpr, 8'h00);
        chk1("rst_fgi", fgi, 1'b0);
        chk1("rst_kbd_ready", kbd_ready, 1'b1);
        chk1("rst_fgo", fgo, 1'b1);
        chk1("rst_prn_valid", prn_valid, 1'b0);
        chk8("rst_prn_data", prn_data, 8'h00);
        chk1("rst_ien", ien, 1'b0);
        chk1("rst_irq", irq, 1'b0);
        chk1("rst_out_ovr", out_ovr, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Two pushes, two pops
        kbd_valid = 1'b1; kbd_data = 8'h41; kbd_q.push_back(8'h41);
        tick();
        chk1("push1_fgi", fgi, 1'b1);
        kbd_data = 8'h42; kbd_q.push_back(8'h42);
        tick();
        kbd_valid = 1'b0;
        exp8 = kbd_q.pop_front();
        chk8("pop1_inpr", inpr, exp8);
        inp_ack = 1'b1;
        tick();
        inp_ack = 1'b0;
        exp8 = kbd_q.pop_front();
        chk8("pop2_inpr", inpr, exp8);
        chk1("pop2_fgi", fgi, 1'b1);
        inp_ack = 1'b1;
        tick();
        inp_ack = 1'b0;
        chk8("empty_inpr", inpr, 8'h00);
        chk1("empty_fgi", fgi, 1'b0);

        // Pop request into an empty FIFO is ignored even with a same-cycle push
        kbd_valid = 1'b1; kbd_data = 8'h77; inp_ack = 1'b1; kbd_q.push_back(8'h77);
        tick();
        kbd_valid = 1'b0; inp_ack = 1'b0;
        chk1("emptypop_fgi", fgi, 1'b1);
        exp8 = kbd_q.pop_front();
        chk8("emptypop_inpr", inpr, exp8);
        inp_ack = 1'b1;
        tick();
        inp_ack = 1'b0;
        chk1("emptypop_drained", fgi, 1'b0);

        // Fill past full; fifth character is refused
        model_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            kbd_valid = 1'b1; kbd_data = 8'hA0 + 8'(i);
            chk1("fill_kbd_ready", kbd_ready, model_cnt < 4);
            if (model_cnt < 4) begin
                kbd_q.push_back(kbd_data);
                model_cnt++;
            end
            tick();
        end
        kbd_valid = 1'b0;
        chk1("full_kbd_ready", kbd_ready, 1'b0);
        for (int i = 0; i < 8 && kbd_q.size() > 0; i++) begin
            exp8 = kbd_q.pop_front();
            chk8("drain_inpr", inpr, exp8);
            inp_ack = 1'b1;
            if (i == 1) begin
                kbd_valid = 1'b1; kbd_data = 8'hC5; kbd_q.push_back(8'hC5);
            end
            tick();
            inp_ack = 1'b0; kbd_valid = 1'b0;
        end
        chk1("drain_fgi", fgi, 1'b0);
        chk1("drain_kbd_ready", kbd_ready, 1'b1);

        // Output transfer with a stalled printer and an overrun attempt
        outr_data = 8'h5A; out_ld = 1'b1; prn_q.push_back(8'h5A);
        tick();
        out_ld = 1'b0;
        chk1("send_prn_valid", prn_valid, 1'b1);
        chk1("send_fgo", fgo, 1'b0);
        chk8("send_prn_data", prn_data, prn_q[0]);
        outr_data = 8'h33; out_ld = 1'b1;
        tick();
        out_ld = 1'b0;
        chk1("ovr_pulse", out_ovr, 1'b1);
        chk8("ovr_prn_data", prn_data, prn_q[0]);
        chk1("ovr_fgo", fgo, 1'b0);
        tick();
        chk1("ovr_single", out_ovr, 1'b0);
        chk1("stall_prn_valid", prn_valid, 1'b1);
        exp8 = prn_q.pop_front();
        chk8("hs_prn_data", prn_data, exp8);
        prn_ready = 1'b1;
        tick();
        prn_ready = 1'b0;
        chk1("idle_fgo", fgo, 1'b1);
        chk1("idle_prn_valid", prn_valid, 1'b0);
        chk8("idle_prn_hold", prn_data, 8'h5A);

        // out_ld on the handshake edge is dropped
        outr_data = 8'h66; out_ld = 1'b1; prn_q.push_back(8'h66);
        tick();
        outr_data = 8'h99; prn_ready = 1'b1;
        exp8 = prn_q.pop_front();
        tick();
        out_ld = 1'b0; prn_ready = 1'b0;
        chk1("hsovr_pulse", out_ovr, 1'b1);
        chk1("hsovr_fgo", fgo, 1'b1);
        chk8("hsovr_prn_data", prn_data, exp8);

        // Interrupt enable
        ien_set = 1'b1;
        tick();
        ien_set = 1'b0;
        chk1("ion_ien", ien, 1'b1);
        chk1("ion_irq", irq, 1'b1);
        ien_set = 1'b1; ien_clr = 1'b1;
        tick();
        ien_set = 1'b0; ien_clr = 1'b0;
        chk1("iof_ien", ien, 1'b0);
        chk1("iof_irq", irq, 1'b0);

        // Asynchronous reset mid-transfer with two queued characters
        kbd_valid = 1'b1; kbd_data = 8'h10;
        tick();
        kbd_data = 8'h11; outr_data = 8'h12; out_ld = 1'b1;
        tick();
        kbd_valid = 1'b0; out_ld = 1'b0;
        chk1("pre_rst_prn_valid", prn_valid, 1'b1);
        chk8("pre_rst_inpr", inpr, 8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("arst_prn_valid", prn_valid, 1'b0);
        chk1("arst_fgo", fgo, 1'b1);
        chk1("arst_fgi", fgi, 1'b0);
        chk8("arst_inpr", inpr, 8'h00);
        chk1("arst_kbd_ready", kbd_ready, 1'b1);
        chk8("arst_prn_data", prn_data, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        chk1("post_rst_prn_valid", prn_valid, 1'b0);
        chk1("post_rst_fgi", fgi, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
